// File: rtl/sdram_bist_pkg.sv
// ============================================================================
// Module   : sdram_bist_pkg
// Brief    : Shared types and constants for the SDRAM BIST initiator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sdram_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_REQ = 3'd1,
        ST_WR_DAT = 3'd2,
        ST_RD_REQ = 3'd3,
        ST_RD_DAT = 3'd4,
        ST_RD_FIN = 3'd5,
        ST_DONE   = 3'd6,
        ST_FAIL   = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISMATCH = 2'd1,
        ERR_TIMEOUT  = 2'd2
    } err_e;

    // x^32 + x^22 + x^2 + x + 1, x^32 term implicit
    localparam logic [31:0] LFSR_POLY = 32'h0040_0007;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], 1'b0} ^ (s[31] ? LFSR_POLY : 32'h0000_0000);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sdram_bist_pattern.sv
// ============================================================================
// Module   : sdram_bist_pattern
// Brief    : Expected-data generator; addr+1 by default, Galois LFSR when
//            SDRAM_BIST_PRBS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_bist_pattern
    import sdram_bist_pkg::*;
#(
    parameter int unsigned ADDR_W = 21,
    parameter int unsigned DATA_W = 32,
    parameter logic [31:0] SEED   = 32'hACE1_0001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              advance,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] pattern
);

`ifdef SDRAM_BIST_PRBS_EN
    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;
    logic        unused_addr;

    assign unused_addr = ^addr;

    always_comb begin
        lfsr_d = lfsr_q;
        if (restart) begin
            lfsr_d = SEED;
        end else if (advance) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign pattern = DATA_W'(lfsr_q);
`else
    logic unused_ctl;

    assign unused_ctl = ^{clk, rst, restart, advance, addr};
    // Truncating before the add gives the same result as (addr+1) mod 2^DATA_W
    assign pattern    = DATA_W'(addr) + DATA_W'(1);
`endif

endmodule

`default_nettype wire

// File: rtl/sdram_bist.sv
// ============================================================================
// Module   : sdram_bist
// Brief    : Write-all / read-all / compare initiator for the SDRAM controller
//            request-ack-done interface. Macro SDRAM_BIST_PRBS_EN: LFSR data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_bist
    import sdram_bist_pkg::*;
#(
    parameter int unsigned ADDR_W    = 21,
    parameter int unsigned NUM_WORDS = 2097152,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TIMEOUT   = 4095,
    parameter logic [31:0] SEED      = 32'hACE1_0001
) (
    input  logic              sclk,
    input  logic              srst,
    input  logic              start,
    output logic              wr_req,
    input  logic              wr_ack,
    input  logic              wr_done,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_req,
    input  logic              rd_ack,
    input  logic              rd_vld,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_done,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] err_addr,
    output logic [DATA_W-1:0] err_data
);

    localparam int unsigned       WD_W      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]   WD_LIMIT  = WD_W'(TIMEOUT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    err_e                err_code_q, err_code_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
    logic [DATA_W-1:0]   err_data_q, err_data_d;
    logic [DATA_W-1:0]   pat;
    logic                pat_restart;
    logic                pat_advance;
    logic                rd_adv;
    logic                waiting;
    logic                is_last;
    logic                timed_out;

    assign waiting   = state_q inside {ST_WR_REQ, ST_WR_DAT, ST_RD_REQ, ST_RD_DAT, ST_RD_FIN};
    assign is_last   = (addr_q == LAST_ADDR);
    assign timed_out = (TIMEOUT != 0) && waiting && (wd_q >= WD_LIMIT);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        err_code_d  = err_code_q;
        err_addr_d  = err_addr_q;
        err_data_d  = err_data_q;
        pat_restart = 1'b0;
        pat_advance = 1'b0;
        rd_adv      = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (start) begin
                    state_d     = ST_WR_REQ;
                    addr_d      = '0;
                    err_code_d  = ERR_NONE;
                    err_addr_d  = '0;
                    err_data_d  = '0;
                    pat_restart = 1'b1;
                end
            end
            ST_WR_REQ: begin
                if (wr_ack) state_d = ST_WR_DAT;
            end
            ST_WR_DAT: begin
                if (wr_done) begin
                    if (is_last) begin
                        addr_d      = '0;
                        pat_restart = 1'b1;
                        state_d     = ST_RD_REQ;
                    end else begin
                        addr_d      = addr_q + ADDR_W'(1);
                        pat_advance = 1'b1;
                        state_d     = ST_WR_REQ;
                    end
                end
            end
            ST_RD_REQ: begin
                if (rd_ack) state_d = ST_RD_DAT;
            end
            ST_RD_DAT: begin
                if (rd_vld) begin
                    if (rd_data != pat) begin
                        state_d    = ST_FAIL;
                        err_code_d = ERR_MISMATCH;
                        err_addr_d = addr_q;
                        err_data_d = rd_data;
                    end else if (rd_done) begin
                        rd_adv = 1'b1;
                    end else begin
                        state_d = ST_RD_FIN;
                    end
                end else if (rd_done) begin
                    // Burst ended without delivering data
                    state_d    = ST_FAIL;
                    err_code_d = ERR_MISMATCH;
                    err_addr_d = addr_q;
                    err_data_d = '0;
                end
            end
            ST_RD_FIN: begin
                if (rd_done) rd_adv = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (rd_adv) begin
            if (is_last) begin
                state_d = ST_DONE;
            end else begin
                addr_d      = addr_q + ADDR_W'(1);
                pat_advance = 1'b1;
                state_d     = ST_RD_REQ;
            end
        end

        // A handshake landing on the deadline cycle still counts as progress
        if (timed_out && (state_d == state_q)) begin
            state_d    = ST_FAIL;
            err_code_d = ERR_TIMEOUT;
            err_addr_d = addr_q;
            err_data_d = '0;
        end

        if (state_d != state_q) begin
            wd_d = '0;
        end else if (waiting && (TIMEOUT != 0)) begin
            wd_d = wd_q + WD_W'(1);
        end else begin
            wd_d = wd_q;
        end
    end

    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wd_q       <= '0;
            err_code_q <= ERR_NONE;
            err_addr_q <= '0;
            err_data_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wd_q       <= wd_d;
            err_code_q <= err_code_d;
            err_addr_q <= err_addr_d;
            err_data_q <= err_data_d;
        end
    end

    sdram_bist_pattern #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .SEED   (SEED)
    ) u_pattern (
        .clk     (sclk),
        .rst     (srst),
        .restart (pat_restart),
        .advance (pat_advance),
        .addr    (addr_q),
        .pattern (pat)
    );

    assign wr_req   = (state_q == ST_WR_REQ);
    assign rd_req   = (state_q == ST_RD_REQ);
    assign wr_data  = (state_q == ST_WR_DAT) ? pat : '0;
    assign busy     = waiting;
    assign pass     = (state_q == ST_DONE);
    assign fail     = (state_q == ST_FAIL);
    assign err_code = err_code_q;
    assign err_addr = err_addr_q;
    assign err_data = err_data_q;

endmodule

`default_nettype wire

// File: tb/tb_sdram_bist.sv
// ============================================================================
// Module   : tb_sdram_bist
// Brief    : Randomized scoreboard bench for sdram_bist with a behavioural
//            controller/memory responder. Honours SDRAM_BIST_PRBS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sdram_bist;

`ifdef SDRAM_BIST_PRBS_EN
    localparam int NW = 4;
`else
    localparam int NW = 8;
`endif
    localparam int          AW      = 21;
    localparam int          DW      = 32;
    localparam int          TMO     = 16;
    localparam logic [31:0] TB_SEED = 32'hACE1_0001;

    typedef struct packed {
        logic          pass;
        logic          fail;
        logic [1:0]    code;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } status_t;

    logic          sclk = 1'b0;
    logic          srst = 1'b1;
    logic          start = 1'b0;
    logic          wr_req, rd_req, busy, pass, fail;
    logic          wr_ack = 1'b0, wr_done = 1'b0;
    logic          rd_ack = 1'b0, rd_vld = 1'b0, rd_done = 1'b0;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] wr_data, err_data;
    logic [1:0]    err_code;
    logic [AW-1:0] err_addr;

    always #5 sclk = ~sclk;

    sdram_bist #(
        .ADDR_W    (AW),
        .NUM_WORDS (NW),
        .DATA_W    (DW),
        .TIMEOUT   (TMO),
        .SEED      (TB_SEED)
    ) dut (
        .sclk     (sclk),
        .srst     (srst),
        .start    (start),
        .wr_req   (wr_req),
        .wr_ack   (wr_ack),
        .wr_done  (wr_done),
        .wr_data  (wr_data),
        .rd_req   (rd_req),
        .rd_ack   (rd_ack),
        .rd_vld   (rd_vld),
        .rd_data  (rd_data),
        .rd_done  (rd_done),
        .busy     (busy),
        .pass     (pass),
        .fail     (fail),
        .err_code (err_code),
        .err_addr (err_addr),
        .err_data (err_data)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_wr_q[$];
    status_t     exp_st_q[$];

    // Responder configuration and bookkeeping
    int          ack_dly = 2, done_dly = 3;
    bit          never_ack = 0, combine = 0;
    int          fault_kind = 0, fault_idx = 0;
    logic [31:0] fault_val = '0;
    int          n_wr = 0, n_rdreq = 0;
    int          exp_reads = 0, exp_writes = 0;
    logic [31:0] mem [NW];
    int          rsp_ph = 0, rsp_cnt = 0, rsp_idx = 0;
    bit          rsp_wr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Word i's expected data: i+1, or the seed multiplied by x^i modulo the LFSR polynomial
    function automatic logic [31:0] model_pat(input int idx);
`ifdef SDRAM_BIST_PRBS_EN
        logic [32:0] s;
        s = {1'b0, TB_SEED};
        for (int k = 0; k < idx; k++) begin
            s = s << 1;
            if (s[32]) s = s ^ 33'h1_0040_0007;
        end
        return s[31:0];
`else
        return 32'(idx + 1);
`endif
    endfunction

    // Behavioural controller + memory
    initial begin : responder
        logic [31:0] d;
        forever begin
            @(negedge sclk);
            wr_ack = 0; wr_done = 0; rd_ack = 0; rd_vld = 0; rd_done = 0; rd_data = '0;
            if (srst) begin
                rsp_ph = 0;
            end else begin
                case (rsp_ph)
                    0: begin
                        if (wr_req && !never_ack) begin
                            rsp_wr = 1; rsp_cnt = 0; rsp_ph = 1;
                        end else if (rd_req) begin
                            rsp_wr = 0; rsp_cnt = 0; rsp_ph = 1;
                            rsp_idx = n_rdreq; n_rdreq++;
                        end
                    end
                    1: begin
                        rsp_cnt++;
                        if (rsp_cnt >= ack_dly) begin
                            if (rsp_wr) wr_ack = 1; else rd_ack = 1;
                            rsp_cnt = 0; rsp_ph = 2;
                        end
                    end
                    2: begin
                        rsp_cnt++;
                        if (rsp_cnt >= done_dly) begin
                            if (rsp_wr) begin
                                wr_done = 1;
                                if (n_wr < NW) mem[n_wr] = wr_data;
                                n_wr++;
                                rsp_ph = 0;
                            end else begin
                                d = (rsp_idx < NW) ? mem[rsp_idx] : 32'h0;
                                if (fault_kind == 1 && rsp_idx == fault_idx) d = fault_val;
                                if (fault_kind == 2 && rsp_idx == fault_idx) begin
                                    rd_done = 1; rsp_ph = 0;
                                end else if (combine) begin
                                    rd_vld = 1; rd_data = d; rd_done = 1; rsp_ph = 0;
                                end else begin
                                    rd_vld = 1; rd_data = d; rsp_ph = 3;
                                end
                            end
                        end
                    end
                    default: begin
                        rd_done = 1; rsp_ph = 0;
                    end
                endcase
            end
        end
    end

    // Scoreboard monitor: written words and end-of-test status
    initial begin : monitor
        logic    prev_busy;
        status_t e;
        logic [31:0] w;
        prev_busy = 0;
        forever begin
            @(negedge sclk);
            #1;
            if (srst) begin
                prev_busy = 0;
            end else begin
                if (wr_done) begin
                    check("wr_req_dropped", wr_req, 1'b0);
                    if (exp_wr_q.size() == 0) begin
                        check("unexpected_write", 1'b1, 1'b0);
                    end else begin
                        w = exp_wr_q.pop_front();
                        check("wr_data", wr_data, w);
                    end
                end
                if (prev_busy && !busy) begin
                    if (exp_st_q.size() == 0) begin
                        check("unexpected_end", 1'b1, 1'b0);
                    end else begin
                        e = exp_st_q.pop_front();
                        check("st_pass", pass, e.pass);
                        check("st_fail", fail, e.fail);
                        check("st_err_code", err_code, e.code);
                        check("st_err_addr", err_addr, e.addr);
                        check("st_err_data", err_data, e.data);
                    end
                end
                prev_busy = busy;
            end
        end
    end

    task automatic pulse_start();
        @(negedge sclk);
        start = 1;
        @(negedge sclk);
        start = 0;
    endtask

    task automatic launch(input bit push_status);
        status_t e;
        n_wr = 0;
        n_rdreq = 0;
        exp_writes = never_ack ? 0 : NW;
        for (int i = 0; i < exp_writes; i++) exp_wr_q.push_back(model_pat(i));
        e = '0;
        if (never_ack) begin
            e.fail = 1; e.code = 2'd2; exp_reads = 0;
        end else if (fault_kind == 1 && fault_val != model_pat(fault_idx)) begin
            e.fail = 1; e.code = 2'd1; e.addr = AW'(fault_idx); e.data = fault_val;
            exp_reads = fault_idx + 1;
        end else if (fault_kind == 2) begin
            e.fail = 1; e.code = 2'd1; e.addr = AW'(fault_idx); e.data = '0;
            exp_reads = fault_idx + 1;
        end else begin
            e.pass = 1; exp_reads = NW;
        end
        if (push_status) exp_st_q.push_back(e);
        pulse_start();
        #1;
        check("start_wr_req", wr_req, 1'b1);
        check("start_busy", busy, 1'b1);
    endtask

    task automatic wait_done();
        int cyc;
        cyc = 0;
        while (exp_st_q.size() != 0 && cyc < 3000) begin
            @(negedge sclk);
            cyc++;
        end
        if (exp_st_q.size() != 0) begin
            check("run_completion", 1'b0, 1'b1);
            exp_st_q.delete();
            exp_wr_q.delete();
            @(negedge sclk); srst = 1;
            repeat (2) @(negedge sclk);
            srst = 0;
        end
        repeat (8) @(negedge sclk);
        #1;
        check("write_count", 64'(n_wr), 64'(exp_writes));
        check("read_count", 64'(n_rdreq), 64'(exp_reads));
    endtask

    task automatic set_mode(input int a, input int d, input bit c, input int fk, input int fi,
                            input logic [31:0] fv);
        ack_dly = a; done_dly = d; combine = c; fault_kind = fk; fault_idx = fi; fault_val = fv;
        never_ack = 0;
    endtask

    initial begin : main
        int cyc;
        repeat (3) @(negedge sclk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_wr_req", wr_req, 1'b0);
        srst = 0;
        @(negedge sclk);
        #1;
        check("idle_outputs", {busy, wr_req, rd_req, pass, fail, err_code, err_addr, err_data, wr_data},
              '0);

        // Clean memory
        set_mode(2, 3, 0, 0, 0, '0);
        launch(1);
        wait_done();

        // Word 5 reads back as zero
        set_mode(2, 3, 0, 1, (NW > 5) ? 5 : NW - 1, 32'h0);
        launch(1);
        wait_done();

        // Watchdog: no write acknowledge ever arrives
        set_mode(2, 3, 0, 0, 0, '0);
        never_ack = 1;
        launch(1);
        cyc = 0;
        while (!fail && cyc < 100) begin
            @(negedge sclk);
            #1;
            cyc++;
        end
        check("timeout_latency", 64'(cyc), 64'(TMO + 1));
        wait_done();
        never_ack = 0;

        // Reset during the read of word 3, then rerun
        set_mode(2, 3, 0, 0, 0, '0);
        launch(0);
        cyc = 0;
        while (!(n_rdreq >= 4 && rsp_ph == 2) && cyc < 1000) begin
            @(negedge sclk);
            cyc++;
        end
        check("reached_read3", 64'(n_rdreq), 64'd4);
        #3;
        srst = 1;
        #1;
        check("midrst_outputs",
              {busy, wr_req, rd_req, pass, fail, err_code, err_addr, err_data, wr_data}, '0);
        repeat (2) @(negedge sclk);
        srst = 0;
        exp_wr_q.delete();
        launch(1);
        wait_done();

        // Valid and done together on every read
        set_mode(2, 3, 1, 0, 0, '0);
        launch(1);
        wait_done();

        // Randomized timing and faults; run 1 also pulses start while busy
        for (int r = 0; r < 8; r++) begin
            int fi;
            fi = $urandom_range(0, NW - 1);
            set_mode($urandom_range(1, 4), $urandom_range(1, 4), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 2), fi,
                     ($urandom_range(0, 3) == 0) ? model_pat(fi) : $urandom);
            launch(1);
            if (r == 1) begin
                repeat (12) @(negedge sclk);
                pulse_start();
            end
            wait_done();
        end

        check("wr_queue_empty", 64'(exp_wr_q.size()), 64'd0);
        check("st_queue_empty", 64'(exp_st_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : guard
        #2_000_000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

endmodule

`default_nettype wire
